// File: rtl/quantum_int_ctrl_pkg.sv
// Shared definitions for the quantum timer: FSM state encoding, the control-unit
// opcodes that drive it, and the default counter width.
package quantum_int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      PENDING = 2'd2,
      SERVICE = 2'd3
   } state_e;

   localparam logic [5:0] OP_WRITEI  = 6'b011100;
   localparam logic [5:0] OP_WRITEPC = 6'b011101;

   localparam int QNT_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/quantum_int_ctrl_qnt_counter.sv
// Quantum register plus retired-instruction counter; flags the instruction
// that will complete the quantum.
module quantum_int_ctrl_qnt_counter
   import quantum_int_ctrl_pkg::*;
#(
   parameter int CNT_W = QNT_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] quantum,
   output logic [CNT_W-1:0] count,
   output logic             hit
);

   // One extra bit keeps count+1 from wrapping when quantum is all ones.
   assign hit = (({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, quantum});

   always_ff @(posedge clk) begin
      if (reset) begin
         quantum <= '0;
         count   <= '0;
      end else if (load) begin
         quantum <= load_val;
         count   <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/quantum_int_ctrl.sv
// Quantum preemption timer: counts retired instructions, raises int_sig on
// expiry, holds it until the decoder acknowledges, and captures the interrupted PC.
module quantum_int_ctrl
   import quantum_int_ctrl_pkg::*;
#(
   parameter int CNT_W      = QNT_CNT_W_DEFAULT,
   parameter int ADDR_W     = 32,
   parameter bit AUTO_REARM = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic              halt,
   input  logic              write_i,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic              stop_qnt,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              int_sig,
   output logic [ADDR_W-1:0] saved_pc,
   output logic              armed,
   output logic [CNT_W-1:0]  count
);

   state_e           state_q, state_d;
   logic             cnt_en, cnt_clr, cnt_load, hit;
   logic [CNT_W-1:0] quantum;

   quantum_int_ctrl_qnt_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .en       (cnt_en),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (wr_data),
      .quantum  (quantum),
      .count    (count),
      .hit      (hit)
   );

   always_comb begin
      state_d  = state_q;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (write_i && (wr_data != '0)) begin
               cnt_load = 1'b1;
               state_d  = COUNT;
            end
         end
         COUNT: begin
            // A software rewrite beats an expiry landing on the same edge.
            if (write_i) begin
               if (wr_data != '0) cnt_load = 1'b1;
               else               state_d  = IDLE;
            end else if (instr_valid && !halt) begin
               cnt_en = 1'b1;
               if (hit) state_d = PENDING;
            end
         end
         PENDING: begin
            if (stop_qnt) state_d = SERVICE;
         end
         SERVICE: begin
            if (AUTO_REARM) begin
               cnt_clr = 1'b1;
               state_d = COUNT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the transition edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         int_sig  <= 1'b0;
         armed    <= 1'b0;
         saved_pc <= '0;
      end else begin
         state_q <= state_d;
         int_sig <= (state_d == PENDING);
         armed   <= (state_d == COUNT) || (state_d == PENDING);
         if ((state_q == PENDING) && stop_qnt) saved_pc <= pc_in;
      end
   end

endmodule

// File: tb/tb_quantum_int_ctrl.sv
// Bench for quantum_int_ctrl: directed scenarios plus random traffic, checked
// against a behavioural model for both the disarming and auto-rearming variants.
module tb_quantum_int_ctrl;

   localparam int CW = 8;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset, instr_valid, halt, write_i, stop_qnt;
   logic [CW-1:0] wr_data;
   logic [AW-1:0] pc_in;

   logic          int_sig0, armed0, int_sig1, armed1;
   logic [AW-1:0] saved_pc0, saved_pc1;
   logic [CW-1:0] count0, count1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase 0 idle, 1 counting, 2 request pending, 3 service cycle.
   int m_ph[2], m_cnt[2], m_q[2], m_spc[2];

   always #5 clk = ~clk;

   quantum_int_ctrl #(.CNT_W(CW), .ADDR_W(AW), .AUTO_REARM(1'b0)) dut0 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .halt(halt),
      .write_i(write_i), .wr_data(wr_data), .stop_qnt(stop_qnt), .pc_in(pc_in),
      .int_sig(int_sig0), .saved_pc(saved_pc0), .armed(armed0), .count(count0)
   );

   quantum_int_ctrl #(.CNT_W(CW), .ADDR_W(AW), .AUTO_REARM(1'b1)) dut1 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .halt(halt),
      .write_i(write_i), .wr_data(wr_data), .stop_qnt(stop_qnt), .pc_in(pc_in),
      .int_sig(int_sig1), .saved_pc(saved_pc1), .armed(armed1), .count(count1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_edge();
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_ph[d] = 0; m_cnt[d] = 0; m_q[d] = 0; m_spc[d] = 0;
         end else begin
            case (m_ph[d])
               0: if (write_i && wr_data != 0) begin
                     m_q[d] = int'(wr_data); m_cnt[d] = 0; m_ph[d] = 1;
                  end
               1: if (write_i) begin
                     if (wr_data != 0) begin m_q[d] = int'(wr_data); m_cnt[d] = 0; end
                     else m_ph[d] = 0;
                  end else if (instr_valid && !halt) begin
                     m_cnt[d] = m_cnt[d] + 1;
                     if (m_cnt[d] == m_q[d]) m_ph[d] = 2;
                  end
               2: if (stop_qnt) begin m_spc[d] = int'(pc_in); m_ph[d] = 3; end
               default: begin
                  if (d == 1) begin m_cnt[d] = 0; m_ph[d] = 1; end
                  else m_ph[d] = 0;
               end
            endcase
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("d0 int_sig",  32'(int_sig0),  32'(m_ph[0] == 2));
      chk("d0 armed",    32'(armed0),    32'(m_ph[0] == 1 || m_ph[0] == 2));
      chk("d0 count",    32'(count0),    32'(m_cnt[0]));
      chk("d0 saved_pc", 32'(saved_pc0), 32'(m_spc[0]));
      chk("d1 int_sig",  32'(int_sig1),  32'(m_ph[1] == 2));
      chk("d1 armed",    32'(armed1),    32'(m_ph[1] == 1 || m_ph[1] == 2));
      chk("d1 count",    32'(count1),    32'(m_cnt[1]));
      chk("d1 saved_pc", 32'(saved_pc1), 32'(m_spc[1]));
   endtask

   task automatic cyc(input logic wi, input int wd, input logic iv, input logic h, input logic sq);
      reset       = 1'b0;
      write_i     = wi;
      wr_data     = CW'(wd);
      instr_valid = iv;
      halt        = h;
      stop_qnt    = sq;
      step();
   endtask

   task automatic rst_cyc();
      reset = 1'b1; write_i = 1'b0; instr_valid = 1'b0; halt = 1'b0; stop_qnt = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; halt = 1'b0; write_i = 1'b0;
      wr_data = '0; stop_qnt = 1'b0; pc_in = '0;
      for (int i = 0; i < 4; i++) begin m_ph[i%2] = 0; m_cnt[i%2] = 0; m_q[i%2] = 0; m_spc[i%2] = 0; end

      rst_cyc(); rst_cyc();
      chk("reset int_sig", 32'(int_sig0), 32'd0);
      chk("reset armed",   32'(armed0),   32'd0);
      chk("reset count",   32'(count0),   32'd0);
      chk("reset saved",   32'(saved_pc0), 32'd0);

      // Quantum 5: expiry on the edge of the 5th instruction; writes while pending ignored.
      cyc(1, 5, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
      chk("q5 early int", 32'(int_sig0), 32'd0);
      cyc(0, 0, 1, 0, 0);
      chk("q5 int",   32'(int_sig0), 32'd1);
      chk("q5 count", 32'(count0),   32'd5);
      chk("q5 armed", 32'(armed0),   32'd1);
      cyc(1, 7, 0, 0, 0);
      chk("pend write int", 32'(int_sig0), 32'd1);
      chk("pend halt int", 32'(int_sig0), 32'd1);
      halt = 1'b1;
      cyc(0, 0, 1, 1, 0);
      chk("pend halt held", 32'(int_sig0), 32'd1);

      // Acknowledge held two cycles.
      pc_in = 16'h0040;
      cyc(0, 0, 0, 0, 1);
      chk("ack int",   32'(int_sig0),  32'd0);
      chk("ack saved", 32'(saved_pc0), 32'h40);
      chk("ack armed", 32'(armed0),    32'd0);
      pc_in = 16'h0099;
      cyc(0, 0, 0, 0, 1);
      chk("ack2 saved", 32'(saved_pc0), 32'h40);
      chk("ack2 armed", 32'(armed0),    32'd0);
      cyc(0, 0, 0, 0, 0);

      // Quantum 4 with idle and halted cycles in between.
      cyc(1, 4, 0, 0, 0);
      cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 0);
      chk("q4 early int",   32'(int_sig0), 32'd0);
      chk("q4 early count", 32'(count0),   32'd3);
      cyc(0, 0, 1, 0, 0);
      chk("q4 int",   32'(int_sig0), 32'd1);
      chk("q4 count", 32'(count0),   32'd4);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);

      // Rewrite wins over same-cycle expiry.
      cyc(1, 2, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 3, 1, 0, 0);
      chk("prio int",   32'(int_sig0), 32'd0);
      chk("prio count", 32'(count0),   32'd0);
      cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
      chk("prio early int", 32'(int_sig0), 32'd0);
      cyc(0, 0, 1, 0, 0);
      chk("prio int3", 32'(int_sig0), 32'd1);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);

      // Writing zero while counting disarms.
      cyc(1, 3, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      chk("disarm armed", 32'(armed0), 32'd0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
      chk("disarm int", 32'(int_sig0), 32'd0);

      // Quantum 1, then reset while pending.
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("q1 int",   32'(int_sig0), 32'd1);
      chk("q1 count", 32'(count0),   32'd1);
      rst_cyc();
      chk("rst pend int",   32'(int_sig0), 32'd0);
      chk("rst pend armed", 32'(armed0),   32'd0);
      pc_in = 16'h0055;
      cyc(0, 0, 0, 0, 1);
      chk("rst ack saved", 32'(saved_pc0), 32'd0);
      chk("rst ack int",   32'(int_sig0),  32'd0);

      // Auto-rearm variant: interrupts recur every 2 counted instructions.
      cyc(1, 2, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
         chk("rearm int", 32'(int_sig1), 32'd1);
         cyc(0, 0, 0, 0, 1);
         chk("rearm ack", 32'(int_sig1), 32'd0);
         cyc(0, 0, 0, 0, 0);
         chk("rearm armed", 32'(armed1), 32'd1);
         chk("rearm count", 32'(count1), 32'd0);
      end

      // Largest quantum: expiry exactly at all-ones without wrapping.
      rst_cyc();
      cyc(1, 255, 0, 0, 0);
      for (int i = 0; i < 254; i++) cyc(0, 0, 1, 0, 0);
      chk("qmax early int", 32'(int_sig0), 32'd0);
      cyc(0, 0, 1, 0, 0);
      chk("qmax int",   32'(int_sig0), 32'd1);
      chk("qmax count", 32'(count0),   32'd255);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         pc_in = AW'($urandom);
         if ($urandom_range(0, 63) == 0) rst_cyc();
         else cyc(($urandom_range(0, 9) == 0), int'($urandom_range(0, 6)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/quantum_int_ctrl.md
Name: quantum_int_ctrl

Overview:
- Preemption source for the processor control unit: a quantum timer that counts retired instructions and raises the interrupt request consumed by the decoder's interrupt path.
- Software arms it with the writei instruction (WriteI strobe plus register data).
- On expiry it drives int_sig until the decoder answers with stopQnt, latches the interrupted PC, then disarms until software re-arms it.

Parameters:
- CNT_W, 32, quantum/counter width in bits
- ADDR_W, 32, PC width
- AUTO_REARM, 0, 1 = reload the last quantum after service instead of disarming

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  one instruction retires this cycle
- halt  in  1  processor halted (halt/in wait); freezes counting
- write_i  in  1  WriteI strobe from control: load quantum and arm
- wr_data  in  CNT_W  quantum value from register file
- stop_qnt  in  1  stopQnt from control: interrupt accepted this cycle
- pc_in  in  ADDR_W  PC of the instruction currently executing
- int_sig  out  1  interrupt request to control (intSig)
- saved_pc  out  ADDR_W  PC captured at acceptance
- armed  out  1  timer armed (COUNT or PENDING)
- count  out  CNT_W  instructions counted in the current quantum

Behaviour:
- Reset (synchronous, checked first every edge):
  - State goes to IDLE.
  - int_sig, armed and count are 0; saved_pc is 0; the quantum register is 0.
  - A reset mid-quantum or while PENDING drops int_sig on the next edge with no ack required.
- States: IDLE, COUNT, PENDING, SERVICE. All outputs are registered.
- IDLE:
  - write_i with wr_data != 0: load quantum := wr_data, count := 0, go to COUNT.
  - write_i with wr_data == 0: ignored, stay in IDLE.
- COUNT:
  - Increments when instr_valid && !halt; otherwise holds.
  - When an increment would make count == quantum: go to PENDING and set int_sig = 1 on that edge. Latency is exactly quantum counted instructions.
  - write_i takes priority over expiry in the same cycle:
    - wr_data != 0: reload quantum, count := 0, stay in COUNT.
    - wr_data == 0: disarm to IDLE.
- PENDING:
  - int_sig is held at 1; the counter is frozen. halt does not clear the request.
  - stop_qnt: saved_pc := pc_in, int_sig := 0 on the same edge, go to SERVICE.
  - write_i while PENDING is ignored; the request is never lost.
- SERVICE: one cycle, which absorbs the decoder's multi-cycle stopQnt.
  - AUTO_REARM = 0: go to IDLE.
  - AUTO_REARM = 1: count := 0, go to COUNT with the previous quantum.
- stop_qnt outside PENDING: ignored; saved_pc is unchanged.
- Width and wrap rules:
  - Comparison is unsigned.
  - quantum = 1 expires on the first counted instruction.
  - quantum = 2^CNT_W − 1 is legal; count never wraps because expiry precedes overflow.
- armed = 1 in COUNT or PENDING, else 0.
- int_sig never asserts in IDLE.

Decomposition:
- Shared package:
  - State enum (IDLE=2'd0, COUNT=2'd1, PENDING=2'd2, SERVICE=2'd3).
  - Opcode constants shared with the control unit: OP_WRITEI = 6'b011100, OP_WRITEPC = 6'b011101.
  - Default CNT_W.
- Sub-module qnt_counter:
  - Enable, clear and load inputs; holds the quantum register and count.
  - Produces the combinational hit flag count + 1 == quantum.
  - The FSM stays in the top module.

Test Plan:
- Reset, then write_i with wr_data = 5, then 5 cycles of instr_valid → int_sig rises on the edge after the 5th instruction; count = 5; armed = 1.
- Quantum 4, instr_valid toggling 1,0,1,halt=1 (with valid) for 3 cycles, then 1,1 → expiry only after the 4th counted instruction; halted and invalid cycles add nothing.
- PENDING, pc_in = 0x40 and stop_qnt held 2 cycles → saved_pc = 0x40; int_sig drops on the first ack edge; SERVICE then IDLE; armed = 0; the second ack cycle is ignored.
- write_i with wr_data = 3 on the same cycle as expiry of quantum 2 → no int_sig, count = 0, quantum = 3, expiry 3 instructions later. write_i with wr_data = 0 in COUNT → IDLE, no interrupt.
- reset asserted while PENDING → next edge int_sig = 0, IDLE; later stop_qnt has no effect.
- AUTO_REARM = 1, quantum 2 → interrupts recur every 2 counted instructions after each SERVICE cycle.
